// File: rtl/icache_arbiter.sv
// Two-requester i-cache port arbiter: fetch (port 0) and prefetch (port 1) share one read
// port, with an in-order ID FIFO routing responses and flush-kill of in-flight reads.
// Define ICACHE_ARB_RR_EN for round-robin arbitration (default build is fixed priority).
module icache_arbiter #(
  parameter int DEPTH  = 2,
  parameter int XLEN   = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              flush_i,
  input  logic [XLEN-1:0]   req0_addr_i,
  input  logic              req0_valid_i,
  output logic              req0_ready_o,
  output logic [DATA_W-1:0] rsp0_data_o,
  output logic              rsp0_valid_o,
  input  logic              rsp0_ready_i,
  input  logic [XLEN-1:0]   req1_addr_i,
  input  logic              req1_valid_i,
  output logic              req1_ready_o,
  output logic [DATA_W-1:0] rsp1_data_o,
  output logic              rsp1_valid_o,
  input  logic              rsp1_ready_i,
  output logic [XLEN-1:0]   addr_o,
  output logic              addr_valid_o,
  input  logic              addr_ready_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              data_valid_i,
  output logic              data_ready_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [DEPTH-1:0] id_q, id_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [CW-1:0]    kill_cnt_q, kill_cnt_d;
  logic             lock_q, lock_d;
  logic             lock_id_q, lock_id_d;
`ifdef ICACHE_ARB_RR_EN
  logic             rr_q, rr_d;
`endif

  logic grant;
  logic push;
  logic pop;
  logic fifo_empty;
  logic killing;
  logic head_id;

  // grant = 0 selects port 0, 1 selects port 1; a pending lock overrides arbitration
  always_comb begin
    grant = 1'b0;
    if (lock_q) begin
      grant = lock_id_q;
    end else begin
`ifdef ICACHE_ARB_RR_EN
      if (req0_valid_i && req1_valid_i) grant = rr_q;
      else                              grant = req1_valid_i & ~req0_valid_i;
`else
      grant = req1_valid_i & ~req0_valid_i;
`endif
    end
  end

  assign addr_valid_o = rst_n_i & (req0_valid_i | req1_valid_i)
                      & (count_q < DEPTH_C) & ~flush_i;
  assign addr_o       = grant ? req1_addr_i : req0_addr_i;
  assign push         = addr_valid_o & addr_ready_i;
  assign req0_ready_o = push & ~grant;
  assign req1_ready_o = push & grant;

  assign fifo_empty = (count_q == '0);
  assign killing    = (kill_cnt_q != '0);
  assign head_id    = id_q[rd_ptr_q];

  // killed heads are drained unconditionally so stale data never reaches a requester
  assign data_ready_o = ~fifo_empty & (killing | (head_id ? rsp1_ready_i : rsp0_ready_i));
  assign rsp0_valid_o = data_valid_i & ~fifo_empty & ~killing & ~head_id;
  assign rsp1_valid_o = data_valid_i & ~fifo_empty & ~killing & head_id;
  assign rsp0_data_o  = data_i;
  assign rsp1_data_o  = data_i;
  assign pop          = data_valid_i & data_ready_o;

  always_comb begin
    id_d       = id_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q + CW'(push) - CW'(pop);
    kill_cnt_d = kill_cnt_q;
    lock_d     = lock_q;
    lock_id_d  = lock_id_q;

    if (push) begin
      id_d[wr_ptr_q] = grant;
      wr_ptr_d       = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);

    // no push can happen in a flush cycle, so count minus this pop is what remains
    if (flush_i)             kill_cnt_d = count_q - CW'(pop);
    else if (pop && killing) kill_cnt_d = kill_cnt_q - CW'(1);

    if (flush_i) begin
      lock_d = 1'b0;
    end else if (addr_valid_o && !addr_ready_i) begin
      lock_d    = 1'b1;
      lock_id_d = grant;
    end else if (push) begin
      lock_d = 1'b0;
    end
  end

`ifdef ICACHE_ARB_RR_EN
  assign rr_d = push ? ~grant : rr_q;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      id_q       <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      kill_cnt_q <= '0;
      lock_q     <= 1'b0;
      lock_id_q  <= 1'b0;
`ifdef ICACHE_ARB_RR_EN
      rr_q       <= 1'b0;
`endif
    end else begin
      id_q       <= id_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      kill_cnt_q <= kill_cnt_d;
      lock_q     <= lock_d;
      lock_id_q  <= lock_id_d;
`ifdef ICACHE_ARB_RR_EN
      rr_q       <= rr_d;
`endif
    end
  end

  // a response with nothing outstanding is a cache protocol violation
  a_rsp_when_empty: assert property (@(posedge clk_i) disable iff (!rst_n_i)
                                     !(data_valid_i && fifo_empty));

endmodule
